// File: rtl/drac_pkg.sv
// Core-wide types shared by the FP writeback path: physical register index, 64-bit data bus
// and the requester bundle presented to the FP writeback arbiter.
package drac_pkg;

    localparam int NUM_FP_WB = 2;

    typedef logic [5:0]  phreg_t;
    typedef logic [63:0] bus64_t;

    typedef struct packed {
        logic   valid;
        phreg_t addr;
        bus64_t data;
    } fp_wb_req_t;

    // $clog2 that never returns 0, so single-entry indices still get a 1-bit field
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin selector granting up to NUM_WB requesters per cycle, starting
// the scan at rr_ptr_i; reports the write port of each grant and the pointer after the last grant.
module rr_multi_grant
    import drac_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int NUM_WB  = NUM_FP_WB,
    localparam int PTR_W   = clog2_min1(NUM_REQ),
    localparam int PORT_W  = clog2_min1(NUM_WB)
) (
    input  logic [NUM_REQ-1:0]             valid_i,
    input  logic [PTR_W-1:0]               rr_ptr_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0][PORT_W-1:0] port_idx_o,
    output logic [PTR_W-1:0]               next_ptr_o
);

    always_comb begin
        int cnt;
        int idx;
        grant_o    = '0;
        port_idx_o = '0;
        next_ptr_o = rr_ptr_i;
        cnt        = 0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (valid_i[PTR_W'(idx)] && (cnt < NUM_WB)) begin
                grant_o[PTR_W'(idx)]    = 1'b1;
                port_idx_o[PTR_W'(idx)] = PORT_W'(cnt);
                cnt                     = cnt + 1;
                next_ptr_o              = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file writeback arbiter: round-robin multi-grant over result producers, one-cycle
// registered write ports. Define FP_WB_ARB_STALL_CNT_EN to add the saturating stall_cnt_o counter.
module fp_wb_arbiter
    import drac_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int NUM_WB  = NUM_FP_WB,
    localparam int PTR_W   = clog2_min1(NUM_REQ),
    localparam int PORT_W  = clog2_min1(NUM_WB)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  phreg_t [NUM_REQ-1:0]   req_addr_i,
    input  bus64_t [NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_WB-1:0]      wb_enable_o,
    output phreg_t [NUM_WB-1:0]    wb_addr_o,
    output bus64_t [NUM_WB-1:0]    wb_data_o,
    output logic [PTR_W-1:0]       rr_ptr_o
`ifdef FP_WB_ARB_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt_o
`endif
);

    fp_wb_req_t [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0]                   grant_raw;
    logic [NUM_REQ-1:0]                   grant;
    logic [NUM_REQ-1:0][PORT_W-1:0]       port_idx;
    logic [PTR_W-1:0]                     rr_ptr_grant;
    logic [PTR_W-1:0]                     rr_ptr_reg;
    logic [PTR_W-1:0]                     rr_ptr_next;
    logic [NUM_WB-1:0]                    wb_enable_reg;
    logic [NUM_WB-1:0]                    wb_enable_next;
    phreg_t [NUM_WB-1:0]                  wb_addr_reg;
    phreg_t [NUM_WB-1:0]                  wb_addr_next;
    bus64_t [NUM_WB-1:0]                  wb_data_reg;
    bus64_t [NUM_WB-1:0]                  wb_data_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req[gi]       = '{valid: req_valid_i[gi], addr: req_addr_i[gi], data: req_data_i[gi]};
            assign req_valid[gi] = req[gi].valid;
        end
    endgenerate

    rr_multi_grant #(
        .NUM_REQ (NUM_REQ),
        .NUM_WB  (NUM_WB)
    ) u_rr_multi_grant (
        .valid_i    (req_valid),
        .rr_ptr_i   (rr_ptr_reg),
        .grant_o    (grant_raw),
        .port_idx_o (port_idx),
        .next_ptr_o (rr_ptr_grant)
    );

    assign grant       = flush_i ? '0 : grant_raw;
    assign req_ready_o = grant;
    assign rr_ptr_next = (|grant) ? rr_ptr_grant : rr_ptr_reg;

    // Steer each winner onto its write port; idle ports keep their last addr/data
    always_comb begin
        wb_enable_next = '0;
        wb_addr_next   = wb_addr_reg;
        wb_data_next   = wb_data_reg;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int k = 0; k < NUM_WB; k++) begin
                if (grant[PTR_W'(r)] && (port_idx[PTR_W'(r)] == PORT_W'(k))) begin
                    wb_enable_next[PORT_W'(k)] = 1'b1;
                    wb_addr_next[PORT_W'(k)]   = req[PTR_W'(r)].addr;
                    wb_data_next[PORT_W'(k)]   = req[PTR_W'(r)].data;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_enable_reg <= '0;
            wb_addr_reg   <= '0;
            wb_data_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            wb_enable_reg <= wb_enable_next;
            wb_addr_reg   <= wb_addr_next;
            wb_data_reg   <= wb_data_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign wb_enable_o = wb_enable_reg;
    assign wb_addr_o   = wb_addr_reg;
    assign wb_data_o   = wb_data_reg;
    assign rr_ptr_o    = rr_ptr_reg;

`ifdef FP_WB_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic        stall_event;

    assign stall_event = !flush_i && (|(req_valid & ~grant));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_reg <= '0;
        end else if (stall_event && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

    // A pending request may only be withdrawn across a flush
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
            a_req_hold: assert property (@(posedge clk_i) disable iff (!rstn_i)
                (req_valid_i[gi] && !req_ready_o[gi] && !flush_i) |=> (req_valid_i[gi] || flush_i));
        end
    endgenerate

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: directed vectors push expected writes, a monitor pops them.
module tb_fp_wb_arbiter;
    import drac_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int NUM_WB  = 2;

    logic                 clk;
    logic                 rstn;
    logic                 flush;
    logic [NUM_REQ-1:0]   req_valid;
    phreg_t [NUM_REQ-1:0] req_addr;
    bus64_t [NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_WB-1:0]    wb_enable;
    phreg_t [NUM_WB-1:0]  wb_addr;
    bus64_t [NUM_WB-1:0]  wb_data;
    logic [1:0]           rr_ptr;
`ifdef FP_WB_ARB_STALL_CNT_EN
    logic [31:0]          stall_cnt;
    int                   stall_exp = 0;
`endif

    typedef struct {
        logic [1:0] en;
        phreg_t     a0;
        bus64_t     d0;
        phreg_t     a1;
        bus64_t     d1;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] prev_en = 2'b00;
    int         checks  = 0;
    int         passed  = 0;

    localparam bus64_t D0 = 64'hD000_0000_0000_0000;
    localparam bus64_t D1 = 64'hD000_0000_0000_0001;
    localparam bus64_t D2 = 64'hD000_0000_0000_0002;
    localparam bus64_t D3 = 64'hD000_0000_0000_0003;
    localparam bus64_t DB = 64'hDEAD_BEEF_0000_0001;

    fp_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_WB  (NUM_WB)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .wb_enable_o (wb_enable),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_data),
        .rr_ptr_o    (rr_ptr)
`ifdef FP_WB_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [1:0] en, input phreg_t a0, input bus64_t d0,
                                input phreg_t a1, input bus64_t d1);
        exp_t e;
        e.en = en; e.a0 = a0; e.d0 = d0; e.a1 = a1; e.d1 = d1;
        return e;
    endfunction

    // Monitor: every registered write must match the oldest expected write
    always begin
        @(posedge clk);
        #2;
        if (rstn && (wb_enable != 2'b00)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wb_enable), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_enable", 64'(wb_enable), 64'(mon_e.en));
                if (mon_e.en[0]) begin
                    check("wb_addr0", 64'(wb_addr[0]), 64'(mon_e.a0));
                    check("wb_data0", wb_data[0], mon_e.d0);
                end
                if (mon_e.en[1]) begin
                    check("wb_addr1", 64'(wb_addr[1]), 64'(mon_e.a1));
                    check("wb_data1", wb_data[1], mon_e.d1);
                end
                $display("write en=%b a0=%h a1=%h", wb_enable, wb_addr[0], wb_addr[1]);
            end
        end
    end

    task automatic cycle(input logic [3:0] valid, input logic fl, input logic [3:0] exp_ready,
                         input exp_t e, input logic [1:0] exp_ptr, input string tag);
        @(negedge clk);
        req_valid = valid;
        flush     = fl;
        #1;
        check({tag, " ready"}, 64'(req_ready), 64'(exp_ready));
        if (fl) check({tag, " prev_write"}, 64'(wb_enable), 64'(prev_en));
        if (e.en != 2'b00) exp_q.push_back(e);
`ifdef FP_WB_ARB_STALL_CNT_EN
        if (!fl && ((valid & ~exp_ready) != 4'b0000)) stall_exp++;
`endif
        prev_en = e.en;
        $display("cycle %s valid=%b flush=%b ready=%b", tag, valid, fl, req_ready);
        @(posedge clk);
        #1;
        check({tag, " rr_ptr"}, 64'(rr_ptr), 64'(exp_ptr));
        if (fl) check({tag, " flushed_en"}, 64'(wb_enable), 64'd0);
        flush = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_addr[r] = phreg_t'(8'h10 + r);
            req_data[r] = D0 | 64'(r);
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset en", 64'(wb_enable), 64'd0);
        check("reset ptr", 64'(rr_ptr), 64'd0);
        check("reset addr0", 64'(wb_addr[0]), 64'd0);
        check("reset data1", wb_data[1], 64'd0);
        rstn = 1'b1;

        cycle(4'b1111, 1'b0, 4'b0011, mk(2'b11, 6'h10, D0, 6'h11, D1), 2'd2, "all_a");
        cycle(4'b1111, 1'b0, 4'b1100, mk(2'b11, 6'h12, D2, 6'h13, D3), 2'd0, "all_b");
        cycle(4'b1111, 1'b0, 4'b0011, mk(2'b11, 6'h10, D0, 6'h11, D1), 2'd2, "all_c");

        // Asynchronous reset mid-cycle while a write is on the ports
        #2;
        rstn = 1'b0;
`ifdef FP_WB_ARB_STALL_CNT_EN
        stall_exp = 0;
`endif
        #1;
        check("midreset en", 64'(wb_enable), 64'd0);
        check("midreset ptr", 64'(rr_ptr), 64'd0);
        $display("reset asserted mid-cycle en=%b ptr=%0d", wb_enable, rr_ptr);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        cycle(4'b1111, 1'b0, 4'b0011, mk(2'b11, 6'h10, D0, 6'h11, D1), 2'd2, "post_reset");
        cycle(4'b1111, 1'b1, 4'b0000, mk(2'b00, 6'h0, 64'd0, 6'h0, 64'd0), 2'd2, "flush");

        req_addr[2] = 6'h25;
        req_data[2] = DB;
        cycle(4'b0100, 1'b0, 4'b0100, mk(2'b01, 6'h25, DB, 6'h0, 64'd0), 2'd3, "single_r2");
        req_addr[2] = 6'h12;
        req_data[2] = D2;

        cycle(4'b1001, 1'b0, 4'b1001, mk(2'b11, 6'h13, D3, 6'h10, D0), 2'd1, "wrap");
        cycle(4'b0000, 1'b0, 4'b0000, mk(2'b00, 6'h0, 64'd0, 6'h0, 64'd0), 2'd1, "idle");
        cycle(4'b0110, 1'b0, 4'b0110, mk(2'b11, 6'h11, D1, 6'h12, D2), 2'd3, "mid_pair");
        cycle(4'b1010, 1'b0, 4'b1010, mk(2'b11, 6'h13, D3, 6'h11, D1), 2'd2, "wrap_pair");
        cycle(4'b0111, 1'b0, 4'b0101, mk(2'b11, 6'h12, D2, 6'h10, D0), 2'd1, "three_a");
        cycle(4'b0010, 1'b0, 4'b0010, mk(2'b01, 6'h11, D1, 6'h0, 64'd0), 2'd2, "three_b");
        cycle(4'b0000, 1'b0, 4'b0000, mk(2'b00, 6'h0, 64'd0, 6'h0, 64'd0), 2'd2, "drain");

        repeat (3) @(posedge clk);
        #3;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef FP_WB_ARB_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
Shares the FP register file write ports among several FP result producers: FPU pipes, the FP load path and int-to-FP moves. Each cycle it selects up to NUM_WB requesters in round-robin order. The winners are registered and driven onto the regfile write_enable/write_addr/write_data ports one cycle later. Losing requesters hold their request until granted.

Parameters:
NUM_REQ, 4, number of result producers (min 1, max 8)
NUM_WB, drac_pkg::NUM_FP_WB (2), number of regfile write ports (1..NUM_REQ)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; drops this cycle's grants and the output stage
req_valid_i  in  NUM_REQ  requester has a result
req_addr_i  in  NUM_REQ x phreg_t  destination physical register
req_data_i  in  NUM_REQ x bus64_t  result data
req_ready_o  out  NUM_REQ  grant: result accepted this cycle
wb_enable_o  out  NUM_WB  regfile write enable per port
wb_addr_o  out  NUM_WB x phreg_t  regfile write address per port
wb_data_o  out  NUM_WB x bus64_t  regfile write data per port
rr_ptr_o  out  $clog2(NUM_REQ) (min 1)  current round-robin head, for debug

Behaviour:
- Reset (async, rstn_i low): wb_enable_o=0, wb_addr_o=0, wb_data_o=0, rr_ptr=0. req_ready_o is combinational; it reads 0 while flush_i=1 and the grant logic otherwise sees no valid requests.
- Handshake: a transfer occurs when req_valid_i[r] && req_ready_o[r]. A requester must hold valid, addr and data stable until granted. req_ready_o[r] must not depend combinationally on req_valid_i of r alone; it is a function of all valids and rr_ptr.
- Selection: scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first NUM_WB valid requesters are granted. The k-th grant in scan order maps to write port k.
- Pointer update: if at least one grant, rr_ptr <= (index of last granted + 1) mod NUM_REQ. If no grant, rr_ptr holds.
- Latency: 1 cycle from grant to wb_enable_o. Output registers load every cycle. Ungranted ports load enable=0; their addr/data hold the previous value.
- Fewer valid requests than NUM_WB: the unused high-numbered ports have enable=0.
- Flush: with flush_i=1, req_ready_o=0, the next-cycle wb_enable_o is all 0, and rr_ptr holds. A write already on wb_*_o during the flush cycle still completes, since it was registered one cycle earlier.
- Duplicate destination addresses among simultaneous winners are not checked; rename guarantees uniqueness.
- Assertion (sim only): req_valid_i[r] must not drop while req_ready_o[r]=0, except under flush_i.
- Fairness: a continuously valid requester is granted within ceil(NUM_REQ/NUM_WB) cycles of non-flush operation.

Optional Feature:
Macro FP_WB_ARB_STALL_CNT_EN.
- With it: adds output stall_cnt_o [31:0], a saturating counter incremented each cycle at least one valid requester is not granted, flush cycles excluded. It resets to 0, saturates at 32'hFFFF_FFFF and does not wrap.
- Without it: the port and counter are absent. Arbitration behaviour is identical in both builds.

Decomposition:
- drac_pkg: NUM_FP_WB, phreg_t and bus64_t already exist there. Add the fp_wb_req_t struct {valid, addr, data} for requester bundles.
- Sub-module: rr_multi_grant (NUM_REQ, NUM_WB). It is purely combinational: takes the valid vector and rr_ptr, and returns the grant vector, a port index per grant and the next pointer.
- The arbiter wraps rr_multi_grant with the output registers, flush and the pointer flop.

Test Plan:
- Reset: assert rstn_i mid-cycle with all req_valid_i=1 -> wb_enable_o=0 immediately and rr_ptr_o=0; after release, first grants are reqs 0,1.
- All 4 valid continuously, NUM_WB=2 -> grants alternate {0,1}, {2,3}, {0,1}. Next cycle wb_addr_o shows matching addresses (e.g. 0x10/0x11, then 0x12/0x13).
- Single request r2 with addr 0x25, data 0xDEAD_BEEF_0000_0001 -> req_ready_o=4'b0100 at once. Next cycle wb_enable_o=2'b01, port 0 carries 0x25/data, port 1 is disabled. rr_ptr becomes 3.
- Wrap-around: rr_ptr=3, valids 4'b1001 -> port 0 gets req3 and port 1 gets req0; rr_ptr becomes 1.
- Flush: valids 4'b1111 with flush_i=1 -> req_ready_o=0, next-cycle wb_enable_o=0, rr_ptr unchanged. The previously registered write still appears during the flush cycle.
- FP_WB_ARB_STALL_CNT_EN: 3 valid requesters for 10 cycles with NUM_WB=2 -> stall_cnt_o counts the cycles with any loser. Preload the counter near saturation and run -> it holds at 32'hFFFF_FFFF.
